// File: rtl/dtree_result_collector_if.sv
// Sample stream from the decision-tree core into the result collector.
//
// Handshake: a sample transfers on a rising clk edge where in_valid and
// in_ready are both 1. in_valid/pred_class/true_class come from the
// producer (master). in_ready comes from the collector (slave) and depends
// only on collector state, never on in_valid.
//
// Signals:
//   in_valid    sample present on pred_class/true_class
//   in_ready    collector accepts a sample this cycle
//   pred_class  classifier output code
//   true_class  golden label code
interface dtree_result_collector_if #(
    parameter int CLASS_W = 4
);
    logic               in_valid;
    logic               in_ready;
    logic [CLASS_W-1:0] pred_class;
    logic [CLASS_W-1:0] true_class;

    modport master (
        output in_valid,
        output pred_class,
        output true_class,
        input  in_ready
    );

    modport slave (
        input  in_valid,
        input  pred_class,
        input  true_class,
        output in_ready
    );
endinterface

// File: rtl/dtree_result_collector.sv
// dtree_result_collector
//   Sink for the classifier evaluation stream. Counts accepted samples,
//   correct predictions, out-of-range predictions and a per-class
//   prediction histogram. After NUM_SAMPLES accepts it stops taking data,
//   raises done and holds its results for readout.
//
// Optional build macro: DTREE_CONF_MATRIX_EN
//   Defined     -> histogram is replaced by a NUM_CLASSES x NUM_CLASSES
//                  confusion matrix indexed [true_class][pred_class].
//   Not defined -> prediction histogram only; rd_true is ignored.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset
//   start         one-cycle pulse: clear all counters and (re)start a run
//   s_if          sample stream (slave modport: in_valid/in_ready/pred/true)
//   busy, done    run in progress / run complete with stable results
//   total_cnt     samples accepted this run
//   correct_cnt   samples with pred_class == true_class
//   oor_cnt       samples with pred_class >= NUM_CLASSES
//   rd_class      histogram (or matrix column) read index
//   rd_true       matrix row read index (matrix build only)
//   rd_count      registered read data, 1-cycle latency
//   dbg_state     FSM state (0 IDLE, 1 RUN, 2 DONE)
module dtree_result_collector #(
    parameter int CLASS_W     = 4,
    parameter int NUM_CLASSES = 6,
    parameter int CNT_W       = 16,
    parameter int NUM_SAMPLES = 320
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    dtree_result_collector_if.slave  s_if,
    output logic                     busy,
    output logic                     done,
    output logic [CNT_W-1:0]         total_cnt,
    output logic [CNT_W-1:0]         correct_cnt,
    output logic [CNT_W-1:0]         oor_cnt,
    input  logic [CLASS_W-1:0]       rd_class,
    input  logic [CLASS_W-1:0]       rd_true,
    output logic [CNT_W-1:0]         rd_count,
    output logic [1:0]               dbg_state
);

    localparam int IDX_W = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
    localparam logic [CLASS_W-1:0] NCLS      = CLASS_W'(NUM_CLASSES);
    localparam logic [CNT_W-1:0]   LAST_SMPL = CNT_W'(NUM_SAMPLES - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic             accept;
    logic             pred_ok;
    logic [IDX_W-1:0] pred_idx;
    logic [IDX_W-1:0] rd_idx;
    logic [CNT_W-1:0] rd_val;

    assign accept   = s_if.in_valid & s_if.in_ready;
    assign pred_ok  = (s_if.pred_class < NCLS);
    assign pred_idx = s_if.pred_class[IDX_W-1:0];
    assign rd_idx   = rd_class[IDX_W-1:0];

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    // start wins in every state, so a start during RUN restarts the run.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (start) state_nxt = RUN;
            RUN: begin
                if (start)
                    state_nxt = RUN;
                else if (accept && total_cnt == LAST_SMPL)
                    state_nxt = DONE;
            end
            DONE: if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    // ---------------- FSM: outputs (state only) ----------------
    always_comb begin
        s_if.in_ready = 1'b0;
        busy          = 1'b0;
        done          = 1'b0;
        case (state)
            RUN: begin
                s_if.in_ready = 1'b1;
                busy          = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign dbg_state = state;

    // ---------------- scalar counters ----------------
    // start has priority over accept: a sample offered in the start cycle
    // is dropped because the run is being cleared.
    always_ff @(posedge clk) begin
        if (rst || start) begin
            total_cnt   <= '0;
            correct_cnt <= '0;
            oor_cnt     <= '0;
        end else if (accept) begin
            total_cnt <= sat_inc(total_cnt);
            if (s_if.pred_class == s_if.true_class)
                correct_cnt <= sat_inc(correct_cnt);
            if (!pred_ok)
                oor_cnt <= sat_inc(oor_cnt);
        end
    end

`ifdef DTREE_CONF_MATRIX_EN
    // ---------------- confusion matrix [true][pred] ----------------
    logic [CNT_W-1:0] cm [NUM_CLASSES][NUM_CLASSES];
    logic             true_ok;
    logic [IDX_W-1:0] true_idx;
    logic [IDX_W-1:0] rd_row;

    assign true_ok  = (s_if.true_class < NCLS);
    assign true_idx = s_if.true_class[IDX_W-1:0];
    assign rd_row   = rd_true[IDX_W-1:0];

    always_ff @(posedge clk) begin
        if (rst || start)
            cm <= '{default: '0};
        else if (accept && pred_ok && true_ok)
            cm[true_idx][pred_idx] <= sat_inc(cm[true_idx][pred_idx]);
    end

    always_comb begin
        rd_val = '0;
        if (rd_class < NCLS && rd_true < NCLS)
            rd_val = cm[rd_row][rd_idx];
    end
`else
    // ---------------- prediction histogram ----------------
    logic [CNT_W-1:0] hist [NUM_CLASSES];

    always_ff @(posedge clk) begin
        if (rst || start)
            hist <= '{default: '0};
        else if (accept && pred_ok)
            hist[pred_idx] <= sat_inc(hist[pred_idx]);
    end

    always_comb begin
        rd_val = '0;
        if (rd_class < NCLS)
            rd_val = hist[rd_idx];
    end

    // Row index only matters for the matrix build.
    logic unused_rd_true;
    assign unused_rd_true = ^rd_true;
`endif

    // Registered readout sees the table before this edge's update.
    always_ff @(posedge clk) begin
        if (rst) rd_count <= '0;
        else     rd_count <= rd_val;
    end

endmodule

// File: tb/tb_dtree_result_collector.sv
// Testbench for dtree_result_collector (NUM_SAMPLES = 4 for short runs).
// Stimulus pushes {selector, expected value} into exp_q; the monitor pops
// and compares each entry against the DUT on the following falling edge.
module tb_dtree_result_collector;

  localparam int CLASS_W     = 4;
  localparam int NUM_CLASSES = 6;
  localparam int CNT_W       = 16;
  localparam int NUM_SAMPLES = 4;
  localparam int W           = 4 + CNT_W;

  // selector codes
  localparam logic [3:0] S_TOTAL = 4'd0;
  localparam logic [3:0] S_CORR  = 4'd1;
  localparam logic [3:0] S_OOR   = 4'd2;
  localparam logic [3:0] S_BUSY  = 4'd3;
  localparam logic [3:0] S_DONE  = 4'd4;
  localparam logic [3:0] S_RDY   = 4'd5;
  localparam logic [3:0] S_RD    = 4'd6;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic               start    = 1'b0;
  logic [CLASS_W-1:0] rd_class = '0;
  logic [CLASS_W-1:0] rd_true  = '0;
  logic               busy, done;
  logic [CNT_W-1:0]   total_cnt, correct_cnt, oor_cnt, rd_count;
  logic [1:0]         dbg_state;

  dtree_result_collector_if #(.CLASS_W(CLASS_W)) bus ();

  dtree_result_collector #(
    .CLASS_W    (CLASS_W),
    .NUM_CLASSES(NUM_CLASSES),
    .CNT_W      (CNT_W),
    .NUM_SAMPLES(NUM_SAMPLES)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .s_if       (bus),
    .busy       (busy),
    .done       (done),
    .total_cnt  (total_cnt),
    .correct_cnt(correct_cnt),
    .oor_cnt    (oor_cnt),
    .rd_class   (rd_class),
    .rd_true    (rd_true),
    .rd_count   (rd_count),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  logic [W-1:0] exp_q[$];
  string        name_q[$];
  int           checks = 0;
  int           errors = 0;

  function automatic logic [CNT_W-1:0] actual(input logic [3:0] sel);
    case (sel)
      S_TOTAL: return total_cnt;
      S_CORR:  return correct_cnt;
      S_OOR:   return oor_cnt;
      S_BUSY:  return CNT_W'(busy);
      S_DONE:  return CNT_W'(done);
      S_RDY:   return CNT_W'(bus.in_ready);
      S_RD:    return rd_count;
      default: return '1;
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [W-1:0]     e;
      string            nm;
      logic [CNT_W-1:0] a;
      e  = exp_q.pop_front();
      nm = name_q.pop_front();
      a  = actual(e[W-1:CNT_W]);
      checks++;
      if (a !== e[CNT_W-1:0]) begin
        errors++;
        $display("FAIL %s actual=%0d expected=%0d", nm, a, e[CNT_W-1:0]);
      end
    end
  end

  // ---------------- driver tasks ----------------
  initial begin
    bus.in_valid   = 1'b0;
    bus.pred_class = '0;
    bus.true_class = '0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_now(input string nm, input logic [CNT_W-1:0] a,
                           input logic [CNT_W-1:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d (immediate)", nm, a, e);
    end
  endtask

  task automatic wait_done(input string nm, input int max_cycles);
    int n;
    n = 0;
    while (done !== 1'b1 && n < max_cycles) begin
      tick();
      n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s timeout waiting for done after %0d cycles", nm,
               max_cycles);
    end
  endtask

  task automatic expect_val(input string nm, input logic [3:0] sel,
                            input int v);
    exp_q.push_back({sel, CNT_W'(v)});
    name_q.push_back(nm);
  endtask

  task automatic expect_counts(input string tag, input int tot,
                               input int cor, input int oor);
    expect_val({tag, "_total"},   S_TOTAL, tot);
    expect_val({tag, "_correct"}, S_CORR,  cor);
    expect_val({tag, "_oor"},     S_OOR,   oor);
  endtask

  task automatic expect_flags(input string tag, input int b, input int d,
                              input int r);
    expect_val({tag, "_busy"},     S_BUSY, b);
    expect_val({tag, "_done"},     S_DONE, d);
    expect_val({tag, "_in_ready"}, S_RDY,  r);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input int p, input int t);
    bus.in_valid   = 1'b1;
    bus.pred_class = CLASS_W'(p);
    bus.true_class = CLASS_W'(t);
    tick();
    bus.in_valid   = 1'b0;
  endtask

  task automatic rd(input string nm, input int cls, input int tru,
                    input int v);
    rd_class = CLASS_W'(cls);
    rd_true  = CLASS_W'(tru);
    tick();
    expect_val(nm, S_RD, v);
  endtask

  // ---------------- directed test sequence ----------------
  initial begin
    // Reset and idle: valid without start must be ignored.
    rst          = 1'b1;
    bus.in_valid = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check_now("rst_state", CNT_W'(dbg_state), CNT_W'(0));
    check_now("rst_in_ready", CNT_W'(bus.in_ready), CNT_W'(0));
    expect_flags("rst", 0, 0, 0);
    expect_counts("rst", 0, 0, 0);
    expect_val("rst_rd_count", S_RD, 0);
    for (int i = 0; i < 3; i++) tick();
    expect_flags("idle", 0, 0, 0);
    expect_counts("idle", 0, 0, 0);
    bus.in_valid = 1'b0;

    // Basic run to completion.
    pulse_start();
    expect_flags("run", 1, 0, 1);
    send(1, 1);
    send(2, 1);
    send(1, 1);
    expect_counts("run3", 3, 2, 0);
    expect_val("run3_done", S_DONE, 0);
    send(5, 5);
    wait_done("run4_wait", 1);
    expect_counts("run4", 4, 3, 0);
    expect_flags("run4", 0, 1, 0);
    bus.in_valid = 1'b1;
    tick();
    tick();
    bus.in_valid = 1'b0;
    expect_counts("hold", 4, 3, 0);
    expect_flags("hold", 0, 1, 0);
    // (class,true) pairs give the same counts in both builds here.
    rd("hist1", 1, 1, 2);
    rd("hist2", 2, 1, 1);
    rd("hist5", 5, 5, 1);
    rd("hist0", 0, 0, 0);
    rd("hist_oor_idx", 9, 9, 0);

    // Out-of-range predictions with bubbles; restart from DONE.
    pulse_start();
    expect_flags("restart", 1, 0, 1);
    expect_counts("restart", 0, 0, 0);
    send(7, 3);
    for (int i = 0; i < 3; i++) tick();
    send(15, 15);
    expect_counts("oor", 2, 1, 2);
    expect_val("oor_done", S_DONE, 0);
    for (int i = 0; i < NUM_CLASSES; i++)
      rd($sformatf("oor_hist%0d", i), i, i, 0);

    // Abort and restart; the sample in the start cycle is dropped.
    pulse_start();
    send(1, 2);
    send(3, 3);
    start          = 1'b1;
    bus.in_valid   = 1'b1;
    bus.pred_class = 4'd4;
    bus.true_class = 4'd4;
    tick();
    start        = 1'b0;
    bus.in_valid = 1'b0;
    expect_counts("abort", 0, 0, 0);
    send(0, 0);
    expect_counts("abort_run", 1, 1, 0);
    rd("abort_hist0", 0, 0, 1);
    rd("abort_hist4", 4, 4, 0);
    rd("abort_hist3", 3, 3, 0);

    // Reset mid-run clears everything.
    pulse_start();
    send(1, 1);
    send(2, 2);
    send(3, 0);
    expect_counts("pre_rst", 3, 2, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expect_flags("midrst", 0, 0, 0);
    expect_counts("midrst", 0, 0, 0);
    for (int i = 0; i < NUM_CLASSES; i++)
      rd($sformatf("midrst_hist%0d", i), i, i, 0);

`ifdef DTREE_CONF_MATRIX_EN
    // Confusion matrix: row = true class, column = predicted class.
    pulse_start();
    send(2, 3);
    send(2, 3);
    send(3, 3);
    expect_counts("cm", 3, 1, 0);
    rd("cm_t3_p2", 2, 3, 2);
    rd("cm_t3_p3", 3, 3, 1);
    rd("cm_t2_p3", 3, 2, 0);
    rd("cm_row_oor", 2, 7, 0);
`endif

    tick();
    tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dtree_result_collector.md
Name: dtree_result_collector

Overview:
- Sink end of the classifier evaluation stream: accepts one predicted class per sample from a decision-tree core, together with the golden label.
- Accumulates total, correct and per-class prediction counts. After a programmed number of samples, flags completion and holds results for readout.
- Sits on-chip behind the tree, so accuracy is measured in hardware rather than by writing every output to a file.

Parameters:
- CLASS_W, 4, width of predicted and true class codes
- NUM_CLASSES, 6, number of valid class codes (0..NUM_CLASSES-1)
- CNT_W, 16, width of every counter
- NUM_SAMPLES, 320, samples per run before done (1 .. 2^CNT_W-1)

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous reset, active-high
- start  input  1  one-cycle pulse, clears counters and begins a run
- in_valid  input  1  sample present on pred_class/true_class
- in_ready  output  1  collector accepts sample this cycle
- pred_class  input  CLASS_W  classifier output
- true_class  input  CLASS_W  golden label
- busy  output  1  run in progress
- done  output  1  run complete, results stable
- total_cnt  output  CNT_W  samples accepted this run
- correct_cnt  output  CNT_W  samples with pred_class==true_class
- oor_cnt  output  CNT_W  samples with pred_class >= NUM_CLASSES
- rd_class  input  CLASS_W  histogram read index
- rd_true  input  CLASS_W  confusion row index (feature only)
- rd_count  output  CNT_W  registered histogram/matrix entry

Behaviour:
- Clock/reset: one clock, clk; reset is synchronous and active-high, rst.
- Reset values: state IDLE; busy=0, done=0, in_ready=0; total_cnt, correct_cnt, oor_cnt, rd_count and all histogram entries = 0.
- FSM IDLE -> RUN: taken on start. All counters and histogram entries clear in the same edge.
- RUN behaviour: in_ready=1, busy=1. Accept = in_valid & in_ready.
- On accept:
  - total_cnt +1.
  - correct_cnt +1 if pred_class==true_class.
  - If pred_class<NUM_CLASSES, hist[pred_class] +1; otherwise oor_cnt +1.
  - An out-of-range prediction can still count as correct if the label matches.
- RUN -> DONE: on the accept that makes total_cnt reach NUM_SAMPLES. The counter update and done=1 are visible on the same following cycle.
- DONE: in_ready=0, busy=0, done=1. Counters hold; in_valid is ignored.
- DONE -> RUN: on start, with counters cleared. done drops the cycle after start.
- start during RUN: aborts and restarts. Counters clear, and any sample presented that cycle is dropped (not counted).
- Saturation: every counter saturates at all-ones and never wraps. Unreachable with default parameters, but must be implemented.
- rst mid-run: returns to IDLE with all counters 0. No partial results are retained.
- Readout:
  - rd_count <= hist[rd_class] on each edge, i.e. 1-cycle latency, valid in any state.
  - rd_class >= NUM_CLASSES returns 0.
  - Reads and counter updates may coincide; the read returns the pre-update value.
- No combinational path from in_valid to in_ready; in_ready is a function of state only.

Optional Feature:
- Macro: DTREE_CONF_MATRIX_EN.
- Defined: the histogram becomes a NUM_CLASSES x NUM_CLASSES confusion matrix.
  - On accept with both codes in range, cm[true_class][pred_class] +1.
  - rd_count <= cm[rd_true][rd_class], 1-cycle latency.
  - Either read index out of range returns 0.
- Not defined: rd_true is unused, and rd_count returns the prediction histogram only.
- total_cnt, correct_cnt and oor_cnt behave identically in both builds.

Test Plan:
- Reset and idle: assert rst 2 cycles, then drive in_valid=1 with no start. Expect in_ready=0 and all counters 0 throughout.
- Basic run, NUM_SAMPLES=4:
  - Stimulus: start, then accepted samples (pred,true) = (1,1), (2,1), (1,1), (5,5).
  - Expect total=4, correct=3, hist[1]=2, hist[2]=1, hist[5]=1.
  - Expect done=1 on the cycle after the 4th accept, with in_ready=0 thereafter.
- Out-of-range and bubbles:
  - Stimulus: samples (7,3), (15,15) with in_valid low for 3 cycles between them.
  - Expect oor_cnt=2, correct=1, total=2, and no histogram change.
- Abort and restart: start, 2 samples, start again with in_valid=1 that cycle, then 1 sample (0,0). Expect total=1, correct=1, hist[0]=1.
- Reset mid-run: after 3 samples, assert rst one cycle. Expect busy=0, done=0, all counters 0, and rd_count=0 for rd_class=0..5.
- DTREE_CONF_MATRIX_EN build: samples (2,3) x2 and (3,3) x1. Expect rd_true=3,rd_class=2 -> 2; rd_true=3,rd_class=3 -> 1; rd_true=2,rd_class=3 -> 0. All reads take 1-cycle latency.
